// File: rtl/mux_2to1_pkg.sv
// Shared definitions for the 2:1 word multiplexer and its users.
package mux_2to1_pkg;

   // Default data MSB: 32-bit words, matching the fetch-stage PC path
   localparam int DEFAULT_MSB = 31;

   // Sequential PC increment used by fetch-stage instances
   localparam int PC_STEP = 4;

   // Meaning of the select line
   typedef enum logic {
      SEL_IN0 = 1'b0,
      SEL_IN1 = 1'b1
   } sel_e;

endpackage : mux_2to1_pkg

// File: rtl/mux_2to1_if.sv
// Bundle of the multiplexer data/select signals.
// The master drives the inputs and select; the slave is the mux itself.
interface mux_2to1_if #(
   parameter int MSB = 31
);
   logic [MSB:0] in0;
   logic [MSB:0] in1;
   logic         sel;
   logic [MSB:0] out;

   modport master (
      output in0,
      output in1,
      output sel,
      input  out
   );

   modport slave (
      input  in0,
      input  in1,
      input  sel,
      output out
   );
endinterface : mux_2to1_if

// File: rtl/mux_2to1.sv
// Parameterised 2:1 word multiplexer.
// REG_OUT=0 gives a purely combinational path (used in the PC-next loop so it
// adds no latency); REG_OUT=1 adds one output register with synchronous reset.
// Port order in0, in1, sel, out, clk, rst keeps old 4-port positional
// instances valid; clk/rst may be left unconnected in combinational mode.
module mux_2to1
   import mux_2to1_pkg::*;
#(
   parameter int MSB     = DEFAULT_MSB,
   parameter bit REG_OUT = 1'b0
) (
   input  logic [MSB:0] in0,
   input  logic [MSB:0] in1,
   input  logic         sel,
   output logic [MSB:0] out,
   input  logic         clk,
   input  logic         rst
);

   logic [MSB:0] selected;

   // Word select written as if/else so an unknown select falls back to in0
   always_comb begin
      selected = in0;
      if (sel == SEL_IN1) begin
         selected = in1;
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [MSB:0] out_q;

         // Output register: reset to zero wins over any select/data activity
         always_ff @(posedge clk) begin
            if (rst) begin
               out_q <= '0;
            end else begin
               out_q <= selected;
            end
         end

         assign out = out_q;
      end else begin : g_comb
         logic unused_clk_rst;

         assign unused_clk_rst = clk ^ rst;
         assign out            = selected;
      end
   endgenerate

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: combinational and registered modes,
// an 8-bit instance, and a small fetch-stage PC loop built around the mux.
module tb_mux_2to1;
   import mux_2to1_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic fetch_rst;

   int compare_count  = 0;
   int mismatch_count = 0;

   always #5 clk = ~clk;

   mux_2to1_if #(.MSB(31)) bus_comb  ();
   mux_2to1_if #(.MSB(31)) bus_reg   ();
   mux_2to1_if #(.MSB(7))  bus_byte  ();
   mux_2to1_if #(.MSB(31)) bus_fetch ();

   mux_2to1 #(.MSB(31), .REG_OUT(1'b0)) u_comb32 (
      .in0(bus_comb.in0), .in1(bus_comb.in1), .sel(bus_comb.sel),
      .out(bus_comb.out), .clk(clk), .rst(rst)
   );

   mux_2to1 #(.MSB(31), .REG_OUT(1'b1)) u_reg32 (
      .in0(bus_reg.in0), .in1(bus_reg.in1), .sel(bus_reg.sel),
      .out(bus_reg.out), .clk(clk), .rst(rst)
   );

   mux_2to1 #(.MSB(7), .REG_OUT(1'b0)) u_comb8 (
      .in0(bus_byte.in0), .in1(bus_byte.in1), .sel(bus_byte.sel),
      .out(bus_byte.out), .clk(clk), .rst(rst)
   );

   mux_2to1 #(.MSB(31), .REG_OUT(1'b0)) u_fetch (
      .in0(bus_fetch.in0), .in1(bus_fetch.in1), .sel(bus_fetch.sel),
      .out(bus_fetch.out), .clk(clk), .rst(fetch_rst)
   );

   // Fetch-stage surroundings: PC register fed by the mux, PC+4 and branch target in
   logic [31:0] pc;
   logic [31:0] branch_addr;
   logic        branch_taken;

   assign bus_fetch.in0 = pc + 32'(PC_STEP);
   assign bus_fetch.in1 = branch_addr;
   assign bus_fetch.sel = branch_taken;

   // PC register of the fetch loop
   always @(posedge clk) begin
      if (fetch_rst) pc <= '0;
      else           pc <= bus_fetch.out;
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive the 32-bit combinational instance and let it settle
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic s);
      bus_comb.in0 = a;
      bus_comb.in1 = b;
      bus_comb.sel = s;
      #1;
   endtask

   // Reference: pick the word whose index is the select value
   function automatic logic [31:0] refPick(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic [31:0] words [2];
      words[0] = a;
      words[1] = b;
      return words[int'(s)];
   endfunction

   initial begin
      logic [31:0] a, b, expected;
      logic        s, r;

      rst          = 1'b1;
      fetch_rst    = 1'b1;
      branch_taken = 1'b0;
      branch_addr  = '0;
      bus_reg.in0  = '0;
      bus_reg.in1  = '0;
      bus_reg.sel  = 1'b0;
      bus_byte.in0 = '0;
      bus_byte.in1 = '0;
      bus_byte.sel = 1'b0;
      applyStimulus('0, '0, 1'b0);

      // Combinational 32-bit: directed vectors
      applyStimulus(32'h0000_0004, 32'h0000_0100, 1'b0);
      checkOutput("comb_sel0", bus_comb.out, 32'h0000_0004);
      applyStimulus(32'h0000_0004, 32'h0000_0100, 1'b1);
      checkOutput("comb_sel1", bus_comb.out, 32'h0000_0100);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      checkOutput("comb_ones_a", bus_comb.out, 32'hFFFF_FFFF);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      checkOutput("comb_zeros", bus_comb.out, 32'h0000_0000);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      checkOutput("comb_ones_b", bus_comb.out, 32'hFFFF_FFFF);

      // Combinational 32-bit: random vectors, some with equal inputs
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = (i % 5 == 0) ? a : $urandom;
         s = 1'($urandom_range(0, 1));
         applyStimulus(a, b, s);
         checkOutput("comb_rand", bus_comb.out, refPick(a, b, s));
      end

      // 8-bit instance: unknown select defaults to in0, equal inputs ignore select
      bus_byte.in0 = 8'hA5;
      bus_byte.in1 = 8'h5A;
      bus_byte.sel = 1'bx;
      #1;
      checkOutput("byte_selx", {24'h0, bus_byte.out}, 32'h0000_00A5);
      bus_byte.sel = 1'b1;
      #1;
      checkOutput("byte_sel1", {24'h0, bus_byte.out}, 32'h0000_005A);
      bus_byte.in0 = 8'h3C;
      bus_byte.in1 = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         bus_byte.sel = 1'(i % 2);
         #1;
         checkOutput("byte_equal", {24'h0, bus_byte.out}, 32'h0000_003C);
      end

      // Registered: reset held for two edges
      @(negedge clk);
      rst = 1'b1;
      bus_reg.sel = 1'b1;
      bus_reg.in1 = 32'hCAFE_0001;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reg_reset", bus_reg.out, 32'h0);

      // Release reset: new data appears exactly one edge later
      @(negedge clk);
      rst = 1'b0;
      bus_reg.sel = 1'b1;
      bus_reg.in1 = 32'hDEAD_BEEF;
      #1;
      checkOutput("reg_before_edge", bus_reg.out, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("reg_latency1", bus_reg.out, 32'hDEAD_BEEF);

      // Mid-stream reset with select/data still active
      @(negedge clk);
      bus_reg.in1 = 32'h1234_5678;
      @(posedge clk);
      #1;
      checkOutput("reg_stream", bus_reg.out, 32'h1234_5678);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reg_midreset", bus_reg.out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reg_resume", bus_reg.out, 32'h1234_5678);

      // Registered: random stream with occasional reset and hold checks between edges
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 7) == 0);
         bus_reg.in0 = a;
         bus_reg.in1 = b;
         bus_reg.sel = s;
         rst         = r;
         expected    = r ? 32'h0 : refPick(a, b, s);
         @(posedge clk);
         #1;
         checkOutput("reg_rand", bus_reg.out, expected);
         bus_reg.in0 = ~a;
         bus_reg.in1 = ~b;
         bus_reg.sel = ~s;
         #2;
         checkOutput("reg_hold", bus_reg.out, expected);
      end
      @(negedge clk);
      rst = 1'b0;

      // Fetch integration: sequential PCs, then a taken branch, then sequential again
      fetch_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fetch_rst = 1'b0;
      checkOutput("fetch_pc0", pc, 32'h0);
      @(negedge clk);
      checkOutput("fetch_pc4", pc, 32'h4);
      @(negedge clk);
      checkOutput("fetch_pc8", pc, 32'h8);
      branch_taken = 1'b1;
      branch_addr  = 32'h0000_0040;
      @(negedge clk);
      checkOutput("fetch_branch", pc, 32'h40);
      branch_taken = 1'b0;
      @(negedge clk);
      checkOutput("fetch_after_branch", pc, 32'h44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule : tb_mux_2to1
